// File: rtl/cmu_pkg.sv
// Shared types and address-field geometry for the 2-way set-associative cache unit.
package cmu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BACK = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned BYTE_W = 2;
  localparam int unsigned DATA_W = 32;

  function automatic int unsigned word_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned set_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned set_lsb(input int unsigned line_words);
    return BYTE_W + word_w(line_words);
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned line_words, input int unsigned sets);
    return set_lsb(line_words) + set_w(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned line_words,
                                        input int unsigned sets);
    return addr_w - tag_lsb(line_words, sets);
  endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: per-set tag/valid/dirty plus line data, synchronous write, combinational read.
module cache_way
  import cmu_pkg::*;
#(
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_W      = 22
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [$clog2(SETS)-1:0]             i_set,
  input  logic [$clog2(LINE_WORDS)-1:0]       i_word,
  input  logic [DATA_W-1:0]                   i_wdata,
  input  logic                                i_wr_en,
  input  logic                                i_mark_dirty,
  input  logic                                i_install,
  input  logic [TAG_W-1:0]                    i_tag,
  output logic                                o_valid,
  output logic                                o_dirty,
  output logic [TAG_W-1:0]                    o_tag,
  output logic [LINE_WORDS-1:0][DATA_W-1:0]   o_line
);

  logic [SETS-1:0]                 r_valid;
  logic [SETS-1:0]                 r_dirty;
  logic [TAG_W-1:0]                r_tag  [SETS];
  logic [LINE_WORDS-1:0][DATA_W-1:0] r_data [SETS];

  // Line state: install makes a line valid and clean; CPU writes dirty it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_install) begin
      r_valid[i_set] <= 1'b1;
      r_dirty[i_set] <= 1'b0;
    end else if (i_mark_dirty) begin
      r_dirty[i_set] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_install) r_tag[i_set] <= i_tag;
    if (i_wr_en)   r_data[i_set][i_word] <= i_wdata;
  end

  assign o_valid = r_valid[i_set];
  assign o_dirty = r_dirty[i_set];
  assign o_tag   = r_tag[i_set];
  assign o_line  = r_data[i_set];

endmodule

// File: rtl/cmu_assoc.sv
// 2-way set-associative write-back cache controller with true-LRU and cs/we/ack line transfers.
module cmu_assoc
  import cmu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_rw,
  input  logic                  en_r,
  input  logic                  en_w,
  input  logic [DATA_W-1:0]     data_w,
  output logic [DATA_W-1:0]     data_r,
  output logic                  stall,
  output logic                  mem_cs_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_W-1:0]     mem_data_o,
  input  logic [DATA_W-1:0]     mem_data_i,
  input  logic                  mem_ack_i
);

  localparam int unsigned WORD_W  = word_w(LINE_WORDS);
  localparam int unsigned SET_W   = set_w(SETS);
  localparam int unsigned SET_LSB = set_lsb(LINE_WORDS);
  localparam int unsigned TAG_LSB = tag_lsb(LINE_WORDS, SETS);
  localparam int unsigned TAG_W   = tag_w(ADDR_WIDTH, LINE_WORDS, SETS);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  state_e                   r_state, w_state_nxt;
  logic [WORD_W-1:0]        r_count, w_count_nxt, w_count_inc;
  logic                     r_victim;
  logic [SET_W-1:0]         r_set;
  logic [TAG_W-1:0]         r_tag;
  logic [SETS-1:0]          r_lru;
  logic                     w_cs_nxt, w_we_nxt;
  logic [ADDR_WIDTH-1:0]    w_addr_nxt;
  logic [DATA_W-1:0]        w_mdata_nxt;

  logic [SET_W-1:0]         w_set, w_arr_set;
  logic [TAG_W-1:0]         w_tag;
  logic [WORD_W-1:0]        w_word, w_wr_word;
  logic [DATA_W-1:0]        w_wr_data;
  logic                     w_idle, w_req, w_hit, w_miss, w_fill_wr;
  logic                     w_victim_sel, w_vic;
  logic [1:0]               w_valid, w_dirty, w_hit_way, w_wr_en, w_mark_dirty, w_install;
  logic [TAG_W-1:0]         w_way_tag [2];
  logic [LINE_WORDS-1:0][DATA_W-1:0] w_line [2];
  logic [LINE_WORDS-1:0][DATA_W-1:0] w_vic_line;
  logic [TAG_W-1:0]         w_vic_tag;
  logic                     w_unused_ok;

  assign w_unused_ok = &{1'b0, addr_rw[BYTE_W-1:0]};

  assign w_word    = addr_rw[BYTE_W +: WORD_W];
  assign w_set     = addr_rw[SET_LSB +: SET_W];
  assign w_tag     = addr_rw[TAG_LSB +: TAG_W];
  assign w_idle    = (r_state == IDLE);
  assign w_req     = en_r | en_w;
  // Miss states work on the latched index so a dropped request still completes.
  assign w_arr_set = w_idle ? w_set : r_set;

  assign w_hit  = |w_hit_way;
  assign w_miss = w_idle & w_req & ~w_hit;
  assign stall  = w_req & ~w_hit;
  assign data_r = w_hit_way[0] ? w_line[0][w_word] :
                  w_hit_way[1] ? w_line[1][w_word] : '0;

  assign w_victim_sel = ~w_valid[0] ? 1'b0 : (~w_valid[1] ? 1'b1 : r_lru[w_set]);
  assign w_vic        = w_idle ? w_victim_sel : r_victim;
  assign w_vic_line   = w_line[w_vic];
  assign w_vic_tag    = w_way_tag[w_vic];
  assign w_count_inc  = r_count + WORD_W'(1);

  assign w_fill_wr = (r_state == FILL) & mem_ack_i;
  assign w_wr_word = w_idle ? w_word : r_count;
  assign w_wr_data = w_idle ? data_w : mem_data_i;

  for (genvar g = 0; g < 2; g++) begin : g_way
    assign w_hit_way[g]    = w_idle & w_valid[g] & (w_way_tag[g] == w_tag);
    assign w_mark_dirty[g] = w_hit_way[g] & en_w;
    assign w_wr_en[g]      = w_mark_dirty[g] | (w_fill_wr & (r_victim == 1'(g)));
    assign w_install[g]    = (r_state == DONE) & (r_victim == 1'(g));

    cache_way #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W)
    ) u_way (
      .clk          (clk),
      .rst          (rst),
      .i_set        (w_arr_set),
      .i_word       (w_wr_word),
      .i_wdata      (w_wr_data),
      .i_wr_en      (w_wr_en[g]),
      .i_mark_dirty (w_mark_dirty[g]),
      .i_install    (w_install[g]),
      .i_tag        (r_tag),
      .o_valid      (w_valid[g]),
      .o_dirty      (w_dirty[g]),
      .o_tag        (w_way_tag[g]),
      .o_line       (w_line[g])
    );
  end

  // LRU bit names the way to evict next.
  always_ff @(posedge clk) begin
    if (rst)                 r_lru <= '0;
    else if (w_req & w_hit)  r_lru[w_set] <= w_hit_way[0];
    else if (r_state == DONE) r_lru[r_set] <= ~r_victim;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_victim   <= 1'b0;
      r_set      <= '0;
      r_tag      <= '0;
      mem_cs_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      mem_cs_o   <= w_cs_nxt;
      mem_we_o   <= w_we_nxt;
      mem_addr_o <= w_addr_nxt;
      mem_data_o <= w_mdata_nxt;
      if (w_miss) begin
        r_victim <= w_victim_sel;
        r_set    <= w_set;
        r_tag    <= w_tag;
      end
    end
  end

  // Next-state and next memory-bus values; bus only moves on entry or after an ack.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_cs_nxt    = mem_cs_o;
    w_we_nxt    = mem_we_o;
    w_addr_nxt  = mem_addr_o;
    w_mdata_nxt = mem_data_o;
    case (r_state)
      IDLE: begin
        if (w_miss) begin
          w_count_nxt = '0;
          w_cs_nxt    = 1'b1;
          if (w_valid[w_vic] & w_dirty[w_vic]) begin
            w_state_nxt = BACK;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = {w_vic_tag, w_set, {WORD_W{1'b0}}, 2'b00};
            w_mdata_nxt = w_vic_line[0];
          end else begin
            w_state_nxt = FILL;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = {w_tag, w_set, {WORD_W{1'b0}}, 2'b00};
          end
        end
      end
      BACK: begin
        if (mem_ack_i) begin
          if (r_count == LAST_WORD) begin
            w_state_nxt = FILL;
            w_count_nxt = '0;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = {r_tag, r_set, {WORD_W{1'b0}}, 2'b00};
          end else begin
            w_count_nxt = w_count_inc;
            w_addr_nxt  = {w_vic_tag, r_set, w_count_inc, 2'b00};
            w_mdata_nxt = w_vic_line[w_count_inc];
          end
        end
      end
      FILL: begin
        if (mem_ack_i) begin
          if (r_count == LAST_WORD) begin
            w_state_nxt = DONE;
            w_count_nxt = '0;
            w_cs_nxt    = 1'b0;
          end else begin
            w_count_nxt = w_count_inc;
            w_addr_nxt  = {r_tag, r_set, w_count_inc, 2'b00};
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmu_assoc.sv
// Scoreboard bench for cmu_assoc: expected CPU and memory transfers are queued, monitors compare.
module tb_cmu_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_rw;
  logic        en_r, en_w;
  logic [31:0] data_w, data_r;
  logic        stall;
  logic        mem_cs_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic        mem_ack_i;

  always #5 clk = ~clk;

  cmu_assoc dut (
    .clk        (clk),
    .rst        (rst),
    .addr_rw    (addr_rw),
    .en_r       (en_r),
    .en_w       (en_w),
    .data_w     (data_w),
    .data_r     (data_r),
    .stall      (stall),
    .mem_cs_o   (mem_cs_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_ack_i  (mem_ack_i)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_mem[$];
  logic [31:0] exp_cpu[$];
  logic [31:0] mem_model [logic [31:0]];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_dly  = 2;
  bit          ack_rand = 1'b0;
  int          ack_count = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'h5A00_0000 | a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_rd_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_mem.push_back('{we: 1'b0, addr: base + 32'(4 * i), data: 32'h0});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_mem.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  task automatic issue(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                       input logic [31:0] exp_rd);
    exp_cpu.push_back(exp_rd);
    @(posedge clk); #1;
    addr_rw = a; en_r = ~wr; en_w = wr; data_w = wd;
  endtask

  task automatic finish_req(output int stall_cycles);
    stall_cycles = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      stall_cycles++;
      if (stall_cycles > 500) begin
        n_checks++; n_fail++;
        $display("FAIL req_timeout: stall still high after %0d cycles", stall_cycles);
        break;
      end
    end
    @(posedge clk); #1;
    en_r = 1'b0; en_w = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; en_r = 1'b0; en_w = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Memory responder and transfer monitor
  initial begin : mem_side
    logic [31:0] a, d;
    logic        we;
    int          dly;
    bit          abort;
    xfer_t       e;
    mem_ack_i  = 1'b0;
    mem_data_i = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (!rst && mem_cs_o) begin
        a = mem_addr_o; we = mem_we_o; d = mem_data_o;
        dly = ack_rand ? int'($urandom_range(6, 1)) : ack_dly;
        abort = 1'b0;
        for (int k = 1; k < dly; k++) begin
          @(negedge clk);
          if (rst) begin abort = 1'b1; break; end
          check("hold_cs", 32'(mem_cs_o), 32'h1);
          check("hold_we", 32'(mem_we_o), 32'(we));
          check("hold_addr", mem_addr_o, a);
          check("hold_data", mem_data_o, d);
        end
        if (!abort && !rst) begin
          if (exp_mem.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL mem_unexpected: we=%0b addr=%08h data=%08h", we, a, d);
          end else begin
            e = exp_mem.pop_front();
            check("mem_we", 32'(we), 32'(e.we));
            check("mem_addr", a, e.addr);
            if (e.we) check("mem_wdata", d, e.data);
          end
          if (we) mem_model[a] = d;
          else    mem_data_i = mem_rd(a);
          mem_ack_i = 1'b1;
          ack_count++;
        end
      end
    end
  end

  // CPU-side monitor: each accepted request is compared with the queued read data
  initial begin : cpu_mon
    forever begin
      @(negedge clk);
      if (!rst && (en_r || en_w) && !stall) begin
        if (exp_cpu.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL cpu_unexpected: data_r=%08h addr=%08h", data_r, addr_rw);
        end else begin
          check("cpu_data_r", data_r, exp_cpu.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int sc, base, guard;
    rst = 1'b1; addr_rw = 32'h0; en_r = 1'b0; en_w = 1'b0; data_w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      mem_model[32'h040 + 32'(4 * i)] = 32'hA0 + 32'(i);
      mem_model[32'h440 + 32'(4 * i)] = 32'hB0 + 32'(i);
      mem_model[32'h840 + 32'(4 * i)] = 32'hC0 + 32'(i);
    end
    do_reset();
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_cs", 32'(mem_cs_o), 32'h0);
    check("rst_we", 32'(mem_we_o), 32'h0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_mdata", mem_data_o, 32'h0);
    check("rst_data_r", data_r, 32'h0);

    // 1: cold read miss, ack 2 cycles after cs
    ack_dly = 2;
    exp_rd_line(32'h040);
    issue(32'h040, 1'b0, 32'h0, 32'hA0);
    finish_req(sc);
    check("t1_stall_cycles", 32'(sc), 32'd10);

    // 2: zero-stall hit
    issue(32'h048, 1'b0, 32'h0, 32'hA2);
    finish_req(sc);
    check("t2_stall_cycles", 32'(sc), 32'd0);

    // 3: dirty LRU victim written back before fill
    issue(32'h040, 1'b1, 32'hDEADBEEF, 32'hA0);
    finish_req(sc);
    check("t3_write_hit_stall", 32'(sc), 32'd0);
    exp_rd_line(32'h440);
    issue(32'h440, 1'b0, 32'h0, 32'hB0);
    finish_req(sc);
    exp_wr(32'h040, 32'hDEADBEEF);
    exp_wr(32'h044, 32'hA1);
    exp_wr(32'h048, 32'hA2);
    exp_wr(32'h04C, 32'hA3);
    exp_rd_line(32'h840);
    issue(32'h840, 1'b0, 32'h0, 32'hC0);
    finish_req(sc);

    // 4: clean LRU victim (way1), no write-back, single-cycle acks
    do_reset();
    ack_dly = 1;
    exp_rd_line(32'h040);
    issue(32'h040, 1'b0, 32'h0, 32'hDEADBEEF);
    finish_req(sc);
    exp_rd_line(32'h440);
    issue(32'h440, 1'b0, 32'h0, 32'hB0);
    finish_req(sc);
    issue(32'h040, 1'b0, 32'h0, 32'hDEADBEEF);
    finish_req(sc);
    check("t4_touch_stall", 32'(sc), 32'd0);
    exp_rd_line(32'h840);
    issue(32'h840, 1'b0, 32'h0, 32'hC0);
    finish_req(sc);
    check("t4_min_miss_cycles", 32'(sc), 32'd6);
    issue(32'h040, 1'b0, 32'h0, 32'hDEADBEEF);
    finish_req(sc);
    check("t4_way0_kept", 32'(sc), 32'd0);

    // 5: random ack latency with write-back round trips in set 0
    ack_rand = 1'b1;
    exp_rd_line(32'h800);
    issue(32'h80C, 1'b1, 32'h11112222, 32'h5A00080C);
    finish_req(sc);
    exp_rd_line(32'h000);
    issue(32'h00C, 1'b1, 32'h33334444, 32'h5A00000C);
    finish_req(sc);
    exp_wr(32'h800, 32'h5A000800);
    exp_wr(32'h804, 32'h5A000804);
    exp_wr(32'h808, 32'h5A000808);
    exp_wr(32'h80C, 32'h11112222);
    exp_rd_line(32'h400);
    issue(32'h40C, 1'b0, 32'h0, 32'h5A00040C);
    finish_req(sc);
    exp_wr(32'h000, 32'h5A000000);
    exp_wr(32'h004, 32'h5A000004);
    exp_wr(32'h008, 32'h5A000008);
    exp_wr(32'h00C, 32'h33334444);
    exp_rd_line(32'h800);
    issue(32'h80C, 1'b0, 32'h0, 32'h11112222);
    finish_req(sc);

    // 6: reset after the second fill ack abandons the line
    ack_rand = 1'b0;
    ack_dly  = 2;
    exp_mem.push_back('{we: 1'b0, addr: 32'h0C0, data: 32'h0});
    exp_mem.push_back('{we: 1'b0, addr: 32'h0C4, data: 32'h0});
    @(posedge clk); #1;
    addr_rw = 32'h0C0; en_r = 1'b1;
    base  = ack_count;
    guard = 0;
    while (ack_count < base + 2 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check("t6_two_acks_seen", 32'(ack_count - base), 32'd2);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_cs_after_rst", 32'(mem_cs_o), 32'h0);
    check("t6_stall_in_rst", 32'(stall), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd_line(32'h0C0);
    exp_cpu.push_back(32'h5A0000C0);
    finish_req(sc);
    check("t6_refill_cycles", 32'(sc), 32'd10);

    repeat (5) @(posedge clk);
    check("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    check("exp_cpu_drained", 32'(exp_cpu.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
